// File: rtl/wramp_mem_responder.sv
// ============================================================================
// Module   : wramp_mem_responder
// Purpose  : CPU memory-bus responder: word RAM, 8N1 serial TX with FIFO, halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wramp_mem_responder #(
    parameter int MEM_WORDS  = 4096,
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic [19:0] mem_address,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_value,
    output logic [31:0] mem_read_value,
    output logic        tx,
    output logic        done,
    output logic        err
);

    localparam int c_aw = $clog2(MEM_WORDS);
    localparam int c_pw = $clog2(FIFO_DEPTH);
    localparam int c_bw = $clog2(BAUD_DIV);
    localparam logic [19:0]     c_addr_txdata = 20'h70000;
    localparam logic [19:0]     c_addr_txstat = 20'h70001;
    localparam logic [19:0]     c_addr_halt   = 20'hFFFFF;
    localparam logic [31:0]     c_halt_magic  = 32'h0000_DEAD;
    localparam logic [c_pw:0]   c_depth       = (c_pw+1)'(FIFO_DEPTH);
    localparam logic [c_bw-1:0] c_baud_last   = c_bw'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [31:0]     r_ram_q  [MEM_WORDS];
    logic [7:0]      r_fifo_q [FIFO_DEPTH];
    state_t          r_state_q, w_state_d;
    logic [c_bw-1:0] r_baud_q, w_baud_d;
    logic [2:0]      r_bit_q, w_bit_d;
    logic [7:0]      r_shift_q, w_shift_d;
    logic            r_tx_q, w_tx_d;
    logic [c_pw-1:0] r_wptr_q, w_wptr_d, r_rptr_q, w_rptr_d;
    logic [c_pw:0]   r_count_q, w_count_d;
    logic            r_ovf_q, w_ovf_d, r_done_q, w_done_d, r_err_q, w_err_d;

    logic w_sel_ram, w_sel_txdata, w_sel_txstat, w_sel_halt, w_sel_unmapped;
    logic w_full, w_empty, w_idle, w_push, w_pop, w_baud_end;

    always_comb begin
        w_sel_ram      = ({12'b0, mem_address} < MEM_WORDS);
        w_sel_txdata   = (mem_address == c_addr_txdata);
        w_sel_txstat   = (mem_address == c_addr_txstat);
        w_sel_halt     = (mem_address == c_addr_halt);
        w_sel_unmapped = !(w_sel_ram || w_sel_txdata || w_sel_txstat || w_sel_halt);
        w_full         = (r_count_q == c_depth);
        w_empty        = (r_count_q == '0);
        w_idle         = w_empty && (r_state_q == S_IDLE);
        w_push         = mem_write_en && w_sel_txdata && !w_full;
        w_baud_end     = (r_baud_q == c_baud_last);
    end

    always_comb begin
        mem_read_value = '0;
        if (w_sel_ram) begin
            mem_read_value = r_ram_q[mem_address[c_aw-1:0]];
        end else if (w_sel_txstat) begin
            mem_read_value = {29'b0, r_ovf_q, w_idle, !w_full};
        end else if (w_sel_halt) begin
            mem_read_value = {31'b0, r_done_q};
        end
    end

    // Shifter FSM, FIFO bookkeeping and status flags
    always_comb begin
        w_state_d = r_state_q;
        w_baud_d  = r_baud_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_pop     = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = r_fifo_q[r_rptr_q];
                    w_baud_d  = '0;
                    w_state_d = S_START;
                end
            end
            S_START: begin
                w_baud_d = r_baud_q + c_bw'(1);
                if (w_baud_end) begin
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_state_d = S_DATA;
                end
            end
            S_DATA: begin
                w_baud_d = r_baud_q + c_bw'(1);
                if (w_baud_end) begin
                    w_baud_d  = '0;
                    w_shift_d = {1'b0, r_shift_q[7:1]};
                    w_bit_d   = r_bit_q + 3'd1;
                    if (r_bit_q == 3'd7) begin
                        w_state_d = S_STOP;
                    end
                end
            end
            default: begin
                w_baud_d = r_baud_q + c_bw'(1);
                if (w_baud_end) begin
                    w_baud_d  = '0;
                    w_state_d = S_IDLE;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_d = r_fifo_q[r_rptr_q];
                        w_state_d = S_START;
                    end
                end
            end
        endcase

        // tx is registered from the next state so it never glitches
        case (w_state_d)
            S_START: w_tx_d = 1'b0;
            S_DATA:  w_tx_d = w_shift_d[0];
            default: w_tx_d = 1'b1;
        endcase

        w_wptr_d  = w_push ? r_wptr_q + c_pw'(1) : r_wptr_q;
        w_rptr_d  = w_pop  ? r_rptr_q + c_pw'(1) : r_rptr_q;
        w_count_d = r_count_q + (c_pw+1)'(w_push) - (c_pw+1)'(w_pop);

        w_ovf_d = r_ovf_q;
        if (mem_write_en && w_sel_txstat) begin
            w_ovf_d = 1'b0;
        end else if (mem_write_en && w_sel_txdata && w_full) begin
            w_ovf_d = 1'b1;
        end
        w_done_d = r_done_q || (mem_write_en && w_sel_halt && (mem_write_value == c_halt_magic));
        w_err_d  = mem_write_en && w_sel_unmapped;
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state_q <= S_IDLE;
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
            r_ovf_q   <= 1'b0;
            r_done_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_baud_q  <= w_baud_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_tx_q    <= w_tx_d;
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
            r_ovf_q   <= w_ovf_d;
            r_done_q  <= w_done_d;
            r_err_q   <= w_err_d;
        end
    end

    // Storage arrays keep their contents across reset
    always_ff @(posedge clk) begin
        if (mem_write_en && w_sel_ram) begin
            r_ram_q[mem_address[c_aw-1:0]] <= mem_write_value;
        end
        if (w_push) begin
            r_fifo_q[r_wptr_q] <= mem_write_value[7:0];
        end
    end

    assign tx   = r_tx_q;
    assign done = r_done_q;
    assign err  = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_wramp_mem_responder.sv
// ============================================================================
// Module   : tb_wramp_mem_responder
// Purpose  : Directed + randomized bench with a serial-line receiver model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wramp_mem_responder;

    localparam logic [19:0] A_TXDATA = 20'h70000;
    localparam logic [19:0] A_TXSTAT = 20'h70001;
    localparam logic [19:0] A_HALT   = 20'hFFFFF;
    localparam int          FRAME    = 40;

    logic        clk = 1'b0;
    logic        rst_async = 1'b0;
    logic [19:0] mem_address = '0;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_write_value = '0;
    logic [31:0] mem_read_value;
    logic        tx, done, err;

    wramp_mem_responder #(
        .MEM_WORDS (256),
        .BAUD_DIV  (4),
        .FIFO_DEPTH(8)
    ) dut (
        .clk            (clk),
        .rst_async      (rst_async),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_value(mem_write_value),
        .mem_read_value (mem_read_value),
        .tx             (tx),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_q[$];
    int          starts[$];
    logic        mon_busy = 1'b0;
    logic [31:0] mdl_ram [256];
    bit          mdl_vld [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One bus cycle, entered and left on a falling edge
    task automatic bus(input logic [19:0] a, input logic we, input logic [31:0] v,
                       output logic [31:0] rd);
        mem_address     = a;
        mem_write_en    = we;
        mem_write_value = v;
        #1 rd = mem_read_value;
        @(negedge clk);
        mem_write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain(input int lim);
        int i = 0;
        while (i < lim && !(exp_q.size() == 0 && !mon_busy)) begin
            @(negedge clk);
            i++;
        end
        chk("drain", {31'b0, (exp_q.size() == 0 && !mon_busy)}, 32'd1);
        idle(3);
    endtask

    // Serial receiver: checks every bit period of each frame against the next expected byte
    initial begin
        logic [7:0] expb, got;
        logic       shape_ok, aborted, eb;
        forever begin
            @(negedge clk);
            if (!rst_async && tx === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                chk("frame_expected", {31'b0, exp_q.size() > 0}, 32'd1);
                expb     = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                got      = '0;
                shape_ok = 1'b1;
                aborted  = 1'b0;
                for (int o = 1; o < FRAME; o++) begin
                    @(negedge clk);
                    if (rst_async) begin
                        aborted = 1'b1;
                        break;
                    end
                    eb = (o < 4) ? 1'b0 : (o < 36) ? expb[(o-4)/4] : 1'b1;
                    if (tx !== eb) shape_ok = 1'b0;
                    if (o >= 4 && o < 36 && (o % 4) == 2) got[(o-4)/4] = tx;
                end
                if (!aborted) begin
                    chk("frame_byte", {24'b0, got}, {24'b0, expb});
                    chk("frame_timing", {31'b0, shape_ok}, 32'd1);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, v;
        int          a, ua;

        // Reset state
        #2 rst_async = 1'b1;
        mem_address = A_TXSTAT;
        #1;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_txstat", mem_read_value, 32'h3);
        idle(2);
        rst_async = 1'b0;
        idle(1);

        // RAM write, read, read-during-write, top word and just past RAM
        bus(20'h00010, 1'b1, 32'h12345678, rd);
        bus(20'h00010, 1'b0, 32'h0, rd);
        chk("ram_rd", rd, 32'h12345678);
        bus(20'h00010, 1'b1, 32'hAAAAAAAA, rd);
        chk("ram_rd_old", rd, 32'h12345678);
        bus(20'h00010, 1'b0, 32'h0, rd);
        chk("ram_rd_new", rd, 32'hAAAAAAAA);
        mdl_ram[16] = 32'hAAAAAAAA; mdl_vld[16] = 1'b1;
        bus(20'h000FF, 1'b1, 32'hCAFEF00D, rd);
        bus(20'h000FF, 1'b0, 32'h0, rd);
        chk("ram_top", rd, 32'hCAFEF00D);
        mdl_ram[255] = 32'hCAFEF00D; mdl_vld[255] = 1'b1;
        bus(20'h00100, 1'b0, 32'h0, rd);
        chk("ram_past_end", rd, 32'h0);

        // Single frame 0x55 with one-cycle start latency
        exp_q.push_back(8'h55);
        bus(A_TXDATA, 1'b1, 32'hFFFFFF55, rd);
        chk("tx_before_pop", {31'b0, tx}, 32'd1);
        idle(1);
        chk("tx_start", {31'b0, tx}, 32'd0);
        bus(A_TXDATA, 1'b0, 32'h0, rd);
        chk("txdata_rd", rd, 32'h0);
        drain(100);
        bus(A_TXSTAT, 1'b0, 32'h0, rd);
        chk("txstat_idle", rd, 32'h3);

        // Back-to-back frames
        starts.delete();
        exp_q.push_back(8'h01);
        bus(A_TXDATA, 1'b1, 32'h01, rd);
        exp_q.push_back(8'h80);
        bus(A_TXDATA, 1'b1, 32'h80, rd);
        drain(200);
        chk("b2b_frames", starts.size(), 32'd2);
        if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], FRAME);

        // Overflow: ten pushes, one in the shifter, eight buffered, last dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'hA0 + 8'(i));
            bus(A_TXDATA, 1'b1, 32'hA0 + i, rd);
        end
        bus(A_TXSTAT, 1'b0, 32'h0, rd);
        chk("ovf_status", rd, 32'h4);
        bus(A_TXSTAT, 1'b1, 32'h0, rd);
        bus(A_TXSTAT, 1'b0, 32'h0, rd);
        chk("ovf_cleared", rd, 32'h0);
        drain(1000);
        bus(A_TXSTAT, 1'b0, 32'h0, rd);
        chk("ovf_drained", rd, 32'h3);

        // Halt and error
        bus(A_HALT, 1'b1, 32'h0000BEEF, rd);
        chk("halt_beef", {31'b0, done}, 32'd0);
        bus(A_HALT, 1'b1, 32'h0000DEAD, rd);
        chk("halt_dead", {31'b0, done}, 32'd1);
        bus(A_HALT, 1'b1, 32'h00000000, rd);
        chk("halt_sticky", {31'b0, done}, 32'd1);
        bus(A_HALT, 1'b0, 32'h0, rd);
        chk("halt_rd", rd, 32'h1);
        chk("err_quiet", {31'b0, err}, 32'd0);
        bus(20'h40000, 1'b1, 32'h5A5A5A5A, rd);
        chk("err_pulse", {31'b0, err}, 32'd1);
        bus(20'h40000, 1'b0, 32'h0, rd);
        chk("unmapped_rd", rd, 32'h0);
        chk("err_one_cycle", {31'b0, err}, 32'd0);

        // Randomized mix against the RAM model and the serial receiver
        for (int it = 0; it < 300; it++) begin
            a = $urandom_range(0, 31);
            v = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    bus(a[19:0], 1'b1, v, rd);
                    if (mdl_vld[a]) chk("rnd_rd_during_wr", rd, mdl_ram[a]);
                    mdl_ram[a] = v;
                    mdl_vld[a] = 1'b1;
                end
                3, 4, 5: begin
                    bus(a[19:0], 1'b0, 32'h0, rd);
                    if (mdl_vld[a]) chk("rnd_rd", rd, mdl_ram[a]);
                end
                6, 7: begin
                    if (exp_q.size() < 6) begin
                        exp_q.push_back(v[7:0]);
                        bus(A_TXDATA, 1'b1, v, rd);
                    end else begin
                        idle(1);
                    end
                end
                8: begin
                    ua = $urandom_range(32'h100, 32'h6FFFF);
                    bus(ua[19:0], 1'b1, v, rd);
                    chk("rnd_unmapped_rd", rd, 32'h0);
                    chk("rnd_err", {31'b0, err}, 32'd1);
                end
                default: begin
                    bus(A_TXSTAT, 1'b0, 32'h0, rd);
                    chk("rnd_no_ovf", {31'b0, rd[2]}, 32'd0);
                end
            endcase
        end
        drain(2000);

        // Reset in the middle of a frame with a byte still queued
        exp_q.push_back(8'h3C);
        bus(A_TXDATA, 1'b1, 32'h3C, rd);
        exp_q.push_back(8'hC3);
        bus(A_TXDATA, 1'b1, 32'hC3, rd);
        idle(12);
        @(posedge clk);
        #2 rst_async = 1'b1;
        mem_address = A_TXSTAT;
        #1;
        chk("midrst_tx", {31'b0, tx}, 32'd1);
        chk("midrst_txstat", mem_read_value, 32'h3);
        chk("midrst_done", {31'b0, done}, 32'd0);
        idle(2);
        rst_async = 1'b0;
        exp_q.delete();
        idle(FRAME + 10);
        chk("post_rst_tx", {31'b0, tx}, 32'd1);
        bus(A_TXSTAT, 1'b0, 32'h0, rd);
        chk("post_rst_txstat", rd, 32'h3);
        bus(20'h00010, 1'b0, 32'h0, rd);
        chk("ram_survives_rst", rd, mdl_ram[16]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
